// File: rtl/apb_store_pkg.sv
// Shared address map, FSM state type and control bit positions for the APB
// result store.
package apb_store_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int unsigned CTRL_CLR_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer result FIFO with an occupancy counter. Synchronous
// active-high reset. Clear has priority over push and pop.
module sync_fifo #(
  parameter int unsigned M     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [M-1:0]             din,
  output logic [M-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [M-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap from DEPTH-1 to 0 is natural overflow.
  always_ff @(posedge PCLK) begin
    if (PRESET || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET && !clr && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/apb_result_store.sv
// APB completer that queues ALU results into a small FIFO, exposes status and
// a clear control, inserts configurable wait states and flags illegal accesses.
module apb_result_store
  import apb_store_pkg::*;
#(
  parameter int unsigned M           = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [1:0]               PADDR,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [M-1:0]             PWDATA,
  output logic                     PREADY,
  output logic [M-1:0]             PRDATA,
  output logic                     PSLVERR,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  apb_state_t    state;
  logic [1:0]    addr_q;
  logic          write_q;
  logic [M-1:0]  wdata_q;
  logic [2:0]    wait_cnt;

  logic          in_access;
  logic          ready;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_clr;
  logic [M-1:0]  fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [M-1:0]  status_word;

  // SETUP is the state held during the first PENABLE cycle, so with W wait
  // states PREADY rises in access cycle W+1 (W=0 gives a two-cycle transfer).
  assign in_access = (state == SETUP || state == ACCESS) && PSEL && PENABLE;
  assign ready     = in_access && (wait_cnt == '0) && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q   <= PADDR;
            write_q  <= PWRITE;
            wdata_q  <= PWDATA;
            wait_cnt <= WAIT_INIT;
            state    <= SETUP;
          end
        end
        SETUP, ACCESS: begin
          if (!in_access) begin
            state <= IDLE;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
            state    <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign status_word = {{(M-CW-2){1'b0}}, fifo_count, fifo_full, fifo_empty};

  always_comb begin
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    PREADY    = ready;
    if (ready) begin
      case (addr_q)
        ADDR_DATA: begin
          if (write_q) begin
            if (fifo_full) PSLVERR = 1'b1;
            else           fifo_push = 1'b1;
          end else begin
            if (fifo_empty) begin
              PSLVERR = 1'b1;
            end else begin
              fifo_pop = 1'b1;
              PRDATA   = fifo_dout;
            end
          end
        end
        ADDR_STATUS: begin
          if (write_q) PSLVERR = 1'b1;
          else         PRDATA  = status_word;
        end
        ADDR_CTRL: begin
          if (write_q && wdata_q[CTRL_CLR_BIT]) fifo_clr = 1'b1;
        end
        default: PSLVERR = 1'b1;
      endcase
    end
  end

  sync_fifo #(
    .M     (M),
    .DEPTH (DEPTH)
  ) u_fifo (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .clr    (fifo_clr),
    .din    (wdata_q),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign o_count = fifo_count;
  assign o_full  = fifo_full;
  assign o_empty = fifo_empty;

endmodule

// File: tb/tb_apb_result_store.sv
// Self-checking bench for apb_result_store: directed scenarios plus random
// transfers checked against a queue-based model of the register map.
module tb_apb_result_store;

  localparam int unsigned M     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 1;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [1:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic [7:0] PRDATA;
  logic       PSLVERR;
  logic [2:0] o_count;
  logic       o_full;
  logic       o_empty;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];

  apb_result_store #(
    .M           (M),
    .DEPTH       (DEPTH),
    .WAIT_STATES (W)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] status_of(input int n);
    logic [7:0] s;
    s    = 8'(n << 2);
    s[1] = (n == DEPTH);
    s[0] = (n == 0);
    return s;
  endfunction

  // Register-map model: returns expected PRDATA/PSLVERR and updates the queue.
  task automatic model_xfer(input logic [1:0] a, input logic wr, input logic [7:0] wd,
                            output logic [7:0] erd, output logic eerr);
    erd  = '0;
    eerr = 1'b0;
    case (a)
      2'd0: begin
        if (wr) begin
          if (q.size() == DEPTH) eerr = 1'b1;
          else                   q.push_back(wd);
        end else begin
          if (q.size() == 0) eerr = 1'b1;
          else               erd = q.pop_front();
        end
      end
      2'd1: begin
        if (wr) eerr = 1'b1;
        else    erd  = status_of(q.size());
      end
      2'd2: if (wr && wd[0]) q.delete();
      default: eerr = 1'b1;
    endcase
  endtask

  task automatic xfer(input logic [1:0] a, input logic wr, input logic [7:0] wd,
                      output logic [7:0] rd, output logic err, output int unsigned ncyc);
    rd   = '0;
    err  = 1'b0;
    ncyc = 0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int unsigned n = 1; n <= 16; n++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        rd   = PRDATA;
        err  = PSLVERR;
        ncyc = n;
        break;
      end
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    checks += 6;
    if (PREADY !== 1'b0)   begin failures++; $display("FAIL reset_pready got=%b exp=0", PREADY); end
    if (PRDATA !== 8'h00)  begin failures++; $display("FAIL reset_prdata got=%h exp=00", PRDATA); end
    if (PSLVERR !== 1'b0)  begin failures++; $display("FAIL reset_pslverr got=%b exp=0", PSLVERR); end
    if (o_count !== 3'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    if (o_empty !== 1'b1)  begin failures++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
    if (o_full !== 1'b0)   begin failures++; $display("FAIL reset_full got=%b exp=0", o_full); end
    q.delete();
  endtask

  task automatic test_status_read();
    logic [7:0] rd; logic err; int unsigned n;
    xfer(2'd1, 1'b0, 8'h00, rd, err, n);
    checks += 3;
    if (n !== W + 1)   begin failures++; $display("FAIL status_latency got=%0d exp=%0d", n, W + 1); end
    if (rd !== 8'h01)  begin failures++; $display("FAIL status_rdata got=%h exp=01", rd); end
    if (err !== 1'b0)  begin failures++; $display("FAIL status_err got=%b exp=0", err); end
  endtask

  logic [7:0] fill_vals [4] = '{8'hA5, 8'h3C, 8'h7F, 8'h11};

  task automatic test_fill_overflow();
    logic [7:0] rd, erd; logic err, eerr; int unsigned n;
    for (int i = 0; i < 4; i++) begin
      model_xfer(2'd0, 1'b1, fill_vals[i], erd, eerr);
      xfer(2'd0, 1'b1, fill_vals[i], rd, err, n);
      checks += 3;
      if (err !== 1'b0)           begin failures++; $display("FAIL fill_err[%0d] got=%b exp=0", i, err); end
      if (o_count !== 3'(i + 1))  begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, o_count, i + 1); end
      if (rd !== 8'h00)           begin failures++; $display("FAIL fill_rdata[%0d] got=%h exp=00", i, rd); end
    end
    checks++;
    if (o_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", o_full); end
    model_xfer(2'd0, 1'b1, 8'hEE, erd, eerr);
    xfer(2'd0, 1'b1, 8'hEE, rd, err, n);
    checks += 2;
    if (err !== 1'b1)      begin failures++; $display("FAIL overflow_err got=%b exp=1", err); end
    if (o_count !== 3'd4)  begin failures++; $display("FAIL overflow_count got=%0d exp=4", o_count); end
  endtask

  task automatic test_drain_underflow();
    logic [7:0] rd, erd; logic err, eerr; int unsigned n;
    for (int i = 0; i < 4; i++) begin
      model_xfer(2'd0, 1'b0, 8'h00, erd, eerr);
      xfer(2'd0, 1'b0, 8'h00, rd, err, n);
      checks += 2;
      if (rd !== fill_vals[i]) begin failures++; $display("FAIL drain_rdata[%0d] got=%h exp=%h", i, rd, fill_vals[i]); end
      if (err !== 1'b0)        begin failures++; $display("FAIL drain_err[%0d] got=%b exp=0", i, err); end
    end
    model_xfer(2'd0, 1'b0, 8'h00, erd, eerr);
    xfer(2'd0, 1'b0, 8'h00, rd, err, n);
    checks += 3;
    if (err !== 1'b1)     begin failures++; $display("FAIL underflow_err got=%b exp=1", err); end
    if (rd !== 8'h00)     begin failures++; $display("FAIL underflow_rdata got=%h exp=00", rd); end
    if (o_empty !== 1'b1) begin failures++; $display("FAIL underflow_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] rd, erd, v; logic err, eerr; int unsigned n;
    logic [7:0] sent [3];
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        v = 8'($urandom);
        sent[i] = v;
        model_xfer(2'd0, 1'b1, v, erd, eerr);
        xfer(2'd0, 1'b1, v, rd, err, n);
      end
      for (int i = 0; i < 3; i++) begin
        model_xfer(2'd0, 1'b0, 8'h00, erd, eerr);
        xfer(2'd0, 1'b0, 8'h00, rd, err, n);
        checks++;
        if (rd !== sent[i] || err !== 1'b0) begin
          failures++; $display("FAIL wrap_rdata[%0d][%0d] got=%h/%b exp=%h/0", r, i, rd, err, sent[i]);
        end
      end
    end
    checks++;
    if (o_count !== 3'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", o_count); end
  endtask

  task automatic test_ctrl_errors();
    logic [7:0] rd, erd; logic err, eerr; int unsigned n;
    for (int i = 0; i < 2; i++) begin
      model_xfer(2'd0, 1'b1, 8'(8'h40 + i), erd, eerr);
      xfer(2'd0, 1'b1, 8'(8'h40 + i), rd, err, n);
    end
    model_xfer(2'd2, 1'b1, 8'h01, erd, eerr);
    xfer(2'd2, 1'b1, 8'h01, rd, err, n);
    checks += 3;
    if (err !== 1'b0)     begin failures++; $display("FAIL clr_err got=%b exp=0", err); end
    if (o_count !== 3'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", o_count); end
    if (o_empty !== 1'b1) begin failures++; $display("FAIL clr_empty got=%b exp=1", o_empty); end

    model_xfer(2'd0, 1'b1, 8'h99, erd, eerr);
    xfer(2'd0, 1'b1, 8'h99, rd, err, n);
    model_xfer(2'd2, 1'b1, 8'hFE, erd, eerr);
    xfer(2'd2, 1'b1, 8'hFE, rd, err, n);
    checks += 2;
    if (err !== 1'b0)     begin failures++; $display("FAIL clr_noop_err got=%b exp=0", err); end
    if (o_count !== 3'd1) begin failures++; $display("FAIL clr_noop_count got=%0d exp=1", o_count); end

    xfer(2'd2, 1'b0, 8'h00, rd, err, n);
    checks++;
    if (rd !== 8'h00 || err !== 1'b0) begin failures++; $display("FAIL ctrl_read got=%h/%b exp=00/0", rd, err); end

    model_xfer(2'd1, 1'b1, 8'hFF, erd, eerr);
    xfer(2'd1, 1'b1, 8'hFF, rd, err, n);
    checks += 2;
    if (err !== 1'b1)     begin failures++; $display("FAIL status_write_err got=%b exp=1", err); end
    if (o_count !== 3'd1) begin failures++; $display("FAIL status_write_count got=%0d exp=1", o_count); end

    xfer(2'd3, 1'b1, 8'h55, rd, err, n);
    checks += 2;
    if (err !== 1'b1)     begin failures++; $display("FAIL rsvd_write_err got=%b exp=1", err); end
    if (o_count !== 3'd1) begin failures++; $display("FAIL rsvd_write_count got=%0d exp=1", o_count); end
    xfer(2'd3, 1'b0, 8'h00, rd, err, n);
    checks++;
    if (err !== 1'b1 || rd !== 8'h00) begin failures++; $display("FAIL rsvd_read got=%h/%b exp=00/1", rd, err); end

    model_xfer(2'd0, 1'b0, 8'h00, erd, eerr);
    xfer(2'd0, 1'b0, 8'h00, rd, err, n);
    checks++;
    if (rd !== 8'h99) begin failures++; $display("FAIL clr_survivor got=%h exp=99", rd); end
  endtask

  task automatic test_no_setup();
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 2'd0; PWRITE = 1'b1; PWDATA = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      checks++;
      if (PREADY !== 1'b0) begin failures++; $display("FAIL nosetup_pready[%0d] got=%b exp=0", i, PREADY); end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    checks++;
    if (o_count !== 3'(q.size())) begin failures++; $display("FAIL nosetup_count got=%0d exp=%0d", o_count, q.size()); end
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic err; int unsigned n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 2'd0; PWRITE = 1'b1; PWDATA = 8'hC3;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    checks++;
    if (PREADY !== 1'b0) begin failures++; $display("FAIL abort_wait_pready got=%b exp=0", PREADY); end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    checks++;
    if (PREADY !== 1'b0) begin failures++; $display("FAIL abort_pready got=%b exp=0", PREADY); end
    @(posedge PCLK); #1;
    checks++;
    if (o_count !== 3'(q.size())) begin failures++; $display("FAIL abort_count got=%0d exp=%0d", o_count, q.size()); end
    xfer(2'd1, 1'b0, 8'h00, rd, err, n);
    checks++;
    if (n !== W + 1 || rd !== status_of(q.size())) begin
      failures++; $display("FAIL abort_followup got=%0d/%h exp=%0d/%h", n, rd, W + 1, status_of(q.size()));
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, erd, wd; logic err, eerr, wr; logic [1:0] a; int unsigned n, r;
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      a  = (r <= 5) ? 2'd0 : (r <= 7) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      if (a == 2'd2 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      model_xfer(a, wr, wd, erd, eerr);
      xfer(a, wr, wd, rd, err, n);
      checks += 4;
      if (n !== W + 1) begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, n, W + 1); end
      if (rd !== erd)  begin failures++; $display("FAIL rnd_rdata[%0d] a=%0d wr=%b got=%h exp=%h", i, a, wr, rd, erd); end
      if (err !== eerr) begin failures++; $display("FAIL rnd_err[%0d] a=%0d wr=%b got=%b exp=%b", i, a, wr, err, eerr); end
      if (o_count !== 3'(q.size()) || o_full !== (q.size() == DEPTH) || o_empty !== (q.size() == 0)) begin
        failures++; $display("FAIL rnd_flags[%0d] got=%0d/%b/%b exp=%0d", i, o_count, o_full, o_empty, q.size());
      end
      repeat ($urandom_range(0, 2)) @(posedge PCLK);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] rd, erd; logic err, eerr; int unsigned n;
    model_xfer(2'd0, 1'b1, 8'h12, erd, eerr);
    xfer(2'd0, 1'b1, 8'h12, rd, err, n);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 2'd0; PWRITE = 1'b1; PWDATA = 8'h5A;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++;
    if (PREADY !== 1'b0) begin failures++; $display("FAIL rstmid_pready_in_reset got=%b exp=0", PREADY); end
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    q.delete();
    @(negedge PCLK);
    checks += 6;
    if (PREADY !== 1'b0)  begin failures++; $display("FAIL rstmid_pready got=%b exp=0", PREADY); end
    if (PRDATA !== 8'h00) begin failures++; $display("FAIL rstmid_prdata got=%h exp=00", PRDATA); end
    if (PSLVERR !== 1'b0) begin failures++; $display("FAIL rstmid_pslverr got=%b exp=0", PSLVERR); end
    if (o_count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", o_count); end
    if (o_empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", o_empty); end
    if (o_full !== 1'b0)  begin failures++; $display("FAIL rstmid_full got=%b exp=0", o_full); end
    xfer(2'd1, 1'b0, 8'h00, rd, err, n);
    checks++;
    if (n !== W + 1 || rd !== 8'h01 || err !== 1'b0) begin
      failures++; $display("FAIL rstmid_followup got=%0d/%h/%b exp=%0d/01/0", n, rd, err, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_status_read();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_ctrl_errors();
    test_no_setup();
    test_abort();
    test_random();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
